// File: rtl/simple_circuit2_checker.sv
// Built-in self-test driver for D = A | (B & C): sweeps all eight {A,B,C}
// vectors, samples the returned D after a settle window and tallies mismatches.
module simple_circuit2_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    output logic             c_out,
    input  logic             d_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [2:0]       fail_vec
);

    localparam int HOLD_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    logic [2:0]        r_vec;
    logic [HOLD_W-1:0] r_hold;

    logic             w_exp;
    logic             w_mis;
    logic             w_sample;
    logic [ERR_W-1:0] w_err_nxt;

    assign w_exp     = r_vec[2] | (r_vec[1] & r_vec[0]);
    assign w_mis     = (d_in != w_exp);
    assign w_sample  = (r_hold == HOLD_LAST);
    // Saturate so a badly broken circuit cannot wrap back to a passing count.
    assign w_err_nxt = (w_mis && (err_count != '1)) ? err_count + ERR_W'(1) : err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_vec      <= '0;
            r_hold     <= '0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            c_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done                  <= 1'b0;
                    {a_out, b_out, c_out} <= 3'b000;
                    if (start) begin
                        r_state    <= S_RUN;
                        r_vec      <= '0;
                        r_hold     <= '0;
                        busy       <= 1'b1;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                        pass       <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_sample) begin
                        err_count <= w_err_nxt;
                        if (w_mis && !fail_valid) begin
                            fail_vec   <= r_vec;
                            fail_valid <= 1'b1;
                        end
                        r_hold <= '0;
                        if (r_vec == 3'd7) begin
                            r_state               <= S_DONE;
                            busy                  <= 1'b0;
                            done                  <= 1'b1;
                            pass                  <= (w_err_nxt == '0);
                            {a_out, b_out, c_out} <= 3'b000;
                        end else begin
                            r_vec                 <= r_vec + 3'd1;
                            {a_out, b_out, c_out} <= r_vec + 3'd1;
                        end
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
